// File: rtl/afifo_wr_arbiter.sv
// afifo_wr_arbiter
// Round-robin arbiter that shares one async-FIFO write port (wclk domain)
// among NUM_REQ valid/ready requesters. A granted requester may stream up to
// MAX_BURST beats before the grant rotates; every grant is preceded by one
// IDLE arbitration cycle. The FIFO is never written while wfull is high.
//
// Optional build macro: AFIFO_WR_ARB_STATS_EN
//   defined   -> adds output stall_cnt[15:0], a saturating count of GRANT
//                cycles in which the granted requester was valid but wfull
//                blocked the write.
//   undefined -> stall_cnt port and counter are absent.

module afifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            wfull,
    output logic                            winc,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
`ifdef AFIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]                     stall_cnt
`endif
);

    // ------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Requester NUM_REQ-1 counts as "last granted" out of reset so that
    // the rotating scan starts at requester 0.
    localparam logic [ID_W-1:0]  LAST_INIT  = ID_W'(NUM_REQ - 1);
    // Beat count value at which the current transfer is the final one.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W:0]    NUM_REQ_W  = (ID_W + 1)'(NUM_REQ);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_reg,    state_next;
    logic [ID_W-1:0]  grant_id_reg, grant_id_next;
    logic [ID_W-1:0]  last_gnt_reg, last_gnt_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    // ------------------------------------------------------------------
    // Grant decode and datapath
    // ------------------------------------------------------------------
    logic                  in_grant;
    logic [NUM_REQ-1:0]    gnt_onehot;
    logic                  gnt_valid;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] slice_masked [NUM_REQ];
    logic [DATA_WIDTH-1:0] gnt_data;

    assign in_grant = (state_reg == ST_GRANT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // One-hot view of the registered grant keeps every index in range
            // even when NUM_REQ is not a power of two.
            assign gnt_onehot[gi]   = (grant_id_reg == ID_W'(gi));
            assign req_ready[gi]    = in_grant & gnt_onehot[gi] & ~wfull;
            assign slice_masked[gi] = gnt_onehot[gi]
                                    ? req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                    : '0;
        end
    endgenerate

    assign gnt_valid = |(req_valid & gnt_onehot);

    // A beat moves only in GRANT, with the owner valid and the FIFO not full.
    assign transfer = in_grant & gnt_valid & ~wfull;

    // AND-OR mux of the granted requester's payload.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_data = gnt_data | slice_masked[i];
        end
    end

    assign winc     = transfer;
    assign wdata    = transfer ? gnt_data : '0;
    assign grant_id = grant_id_reg;
    assign busy     = in_grant;

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    // The request vector is rotated so that bit 0 corresponds to
    // last_gnt+1; a priority encoder then finds the nearest valid
    // requester, and the offset is mapped back to an absolute index.
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [2*NUM_REQ-1:0] rot_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [ID_W:0]        rot_amt;
    logic [ID_W-1:0]      first_off;
    logic [ID_W:0]        pick_sum;
    logic [ID_W:0]        pick_wrap;
    logic [ID_W-1:0]      pick_id;

    assign valid_dbl = {req_valid, req_valid};
    assign rot_amt   = {1'b0, last_gnt_reg} + (ID_W + 1)'(1);
    assign rot_dbl   = valid_dbl >> rot_amt;
    assign valid_rot = rot_dbl[NUM_REQ-1:0];

    // Priority encoder: lowest set bit of the rotated vector wins.
    always_comb begin
        first_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                first_off = ID_W'(j);
            end
        end
    end

    // Map the rotated offset back to a requester index, wrapping once.
    always_comb begin
        pick_sum  = {1'b0, last_gnt_reg} + {1'b0, first_off} + (ID_W + 1)'(1);
        pick_wrap = pick_sum;
        if (pick_sum >= NUM_REQ_W) begin
            pick_wrap = pick_sum - NUM_REQ_W;
        end
        pick_id = pick_wrap[ID_W-1:0];
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // IDLE registers a winner; GRANT counts beats and releases on a full
    // burst or when the owner stops presenting data. A wfull stall changes
    // nothing, so the grant and beat count are simply held.
    always_comb begin
        state_next    = state_reg;
        grant_id_next = grant_id_reg;
        last_gnt_next = last_gnt_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_id_next = pick_id;
                    beat_cnt_next = '0;
                    state_next    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (transfer) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    if (beat_cnt_reg == BURST_LAST) begin
                        last_gnt_next = grant_id_reg;
                        state_next    = ST_IDLE;
                    end
                end else if (!gnt_valid) begin
                    last_gnt_next = grant_id_reg;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg    <= ST_IDLE;
            grant_id_reg <= '0;
            last_gnt_reg <= LAST_INIT;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_id_reg <= grant_id_next;
            last_gnt_reg <= last_gnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

`ifdef AFIFO_WR_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------
    logic [15:0] stall_cnt_reg;

    // Count owner-valid cycles blocked by wfull, holding at all-ones.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stall_cnt_reg <= '0;
        end else if (in_grant && gnt_valid && wfull && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Testbench for afifo_wr_arbiter.
// Requesters are modelled as per-requester queues of pending words that obey
// the valid/ready handshake. A behavioural model of the arbitration rules
// predicts busy/grant_id/req_ready/winc/wdata every cycle; directed phases
// cover the listed scenarios and a random phase mixes traffic with wfull.
`timescale 1ns/1ps

module tb_afifo_wr_arbiter;

    localparam int DW         = 8;
    localparam int NR         = 4;
    localparam int MB         = 4;
    localparam int IDW        = $clog2(NR);
    localparam int FAIR_BOUND = (NR - 1) * (MB + 1) + 1;

    logic              wclk = 1'b0;
    logic              wrst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              wfull = 1'b0;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [IDW-1:0]    grant_id;
    logic              busy;
`ifdef AFIFO_WR_ARB_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    afifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef AFIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester traffic
    logic [DW-1:0] pend [NR][$];
    int p_new         = 0;
    int len_max       = 4;
    int p_full        = 0;
    int full_override = 0;

    // Reference model
    bit             m_busy;
    logic [IDW-1:0] m_gid;
    logic [IDW-1:0] m_last;
    int             m_beats;
    int             m_stall;
    int             wait_cnt [NR];

    // Observation logs
    logic [DW-1:0] wlog [$];
    int            glog [$];
    bit            prev_busy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int glog_at(input int k);
        return (k < glog.size()) ? glog[k] : -1;
    endfunction

    function automatic logic [31:0] wlog_at(input int k);
        return (k < wlog.size()) ? 32'(wlog[k]) : 32'hFFFF_FFFF;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < NR; i++) begin
            if (pend[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = pend[i][0];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic refill();
        int n;
        for (int i = 0; i < NR; i++) begin
            if (pend[i].size() == 0 && int'($urandom_range(99)) < p_new) begin
                n = int'($urandom_range(len_max, 1));
                repeat (n) pend[i].push_back(DW'($urandom));
            end
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) pend[i].delete();
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_gid     = '0;
        m_last    = IDW'(NR - 1);
        m_beats   = 0;
        m_stall   = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        wlog.delete();
        glog.delete();
    endtask

    // Called 1ns after a rising edge; returns before the next falling edge.
    task automatic async_reset();
        #1 wrst_n = 1'b0;
        #1;
        check_val("rst_busy",  32'(busy),      32'd0);
        check_val("rst_winc",  32'(winc),      32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_gid",   32'(grant_id),  32'd0);
        check_val("rst_wdata", 32'(wdata),     32'd0);
        model_reset();
        #1 wrst_n = 1'b1;
    endtask

    // One clock cycle: compare at the falling edge, advance the model,
    // then update requester and wfull stimulus just after the rising edge.
    task automatic step();
        logic [NR-1:0]  exp_ready;
        logic           exp_winc;
        logic [DW-1:0]  exp_wdata;
        logic [NR-1:0]  acc;
        logic           g_valid;
        logic [IDW-1:0] cand;
        @(negedge wclk);
        g_valid   = req_valid[m_gid];
        exp_ready = '0;
        exp_winc  = 1'b0;
        exp_wdata = '0;
        if (m_busy && !wfull) exp_ready[m_gid] = 1'b1;
        if (m_busy && g_valid && !wfull) begin
            exp_winc  = 1'b1;
            exp_wdata = req_data[m_gid*DW +: DW];
        end
        check_val("busy",      32'(busy),      32'(m_busy));
        check_val("grant_id",  32'(grant_id),  32'(m_gid));
        check_val("req_ready", 32'(req_ready), 32'(exp_ready));
        check_val("winc",      32'(winc),      32'(exp_winc));
        check_val("wdata",     32'(wdata),     32'(exp_wdata));
`ifdef AFIFO_WR_ARB_STATS_EN
        check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        if (winc) wlog.push_back(wdata);
        if (busy && !prev_busy) glog.push_back(int'(grant_id));
        prev_busy = busy;

        // Fairness: cycles spent valid but not granted, wfull cycles excluded.
        for (int i = 0; i < NR; i++) begin
            if (busy && grant_id == IDW'(i)) begin
                if (wait_cnt[i] > 0) begin
                    check_val("fair_wait", 32'(wait_cnt[i] <= FAIR_BOUND), 32'd1);
                    wait_cnt[i] = 0;
                end
            end else if (req_valid[i] && !wfull) begin
                wait_cnt[i]++;
                if (wait_cnt[i] == FAIR_BOUND + 1)
                    check_val("fair_starve", 32'(wait_cnt[i]), 32'(FAIR_BOUND));
            end
        end

        // Model advance
        if (m_busy && g_valid && wfull && m_stall < 65535) m_stall++;
        if (!m_busy) begin
            if (req_valid != '0) begin
                for (int k = 1; k <= NR; k++) begin
                    cand = IDW'((int'(m_last) + k) % NR);
                    if (req_valid[cand]) begin
                        m_gid = cand;
                        break;
                    end
                end
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else if (exp_winc) begin
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 1'b0;
                m_last = m_gid;
            end
        end else if (!g_valid) begin
            m_busy = 1'b0;
            m_last = m_gid;
        end

        acc = req_valid & req_ready;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        end
        refill();
        if (full_override >= 0) wfull = full_override[0];
        else                    wfull = (int'($urandom_range(99)) < p_full);
        apply_inputs();
    endtask

    initial begin
        int lv;
        int total;
        model_reset();
        @(posedge wclk);
        #1;
        async_reset();

        // Single requester, three back-to-back beats
        p_new = 0; full_override = 0; wfull = 1'b0;
        pend[1].push_back(8'h11);
        pend[1].push_back(8'h22);
        pend[1].push_back(8'h33);
        apply_inputs();
        repeat (6) step();
        check_val("single_beats", 32'(wlog.size()), 32'd3);
        check_val("single_w0", wlog_at(0), 32'h11);
        check_val("single_w1", wlog_at(1), 32'h22);
        check_val("single_w2", wlog_at(2), 32'h33);
        check_val("single_gnt", 32'(glog_at(0)), 32'd1);
        check_val("single_gid", 32'(grant_id), 32'd1);

        // All requesters continuously valid
        async_reset();
        flush();
        p_new = 100; len_max = 8; full_override = 0; wfull = 1'b0;
        refill();
        apply_inputs();
        repeat (22) step();
        check_val("rr_g0", 32'(glog_at(0)), 32'd0);
        check_val("rr_g1", 32'(glog_at(1)), 32'd1);
        check_val("rr_g2", 32'(glog_at(2)), 32'd2);
        check_val("rr_g3", 32'(glog_at(3)), 32'd3);
        check_val("rr_g4", 32'(glog_at(4)), 32'd0);
        check_val("rr_beats", 32'(wlog.size()), 32'd17);

        // Reset in the middle of a burst
        repeat (3) step();
        async_reset();
        lv = -1;
        for (int i = NR - 1; i >= 0; i--) if (req_valid[i]) lv = i;
        step();
        check_val("rst_first_gid", 32'(grant_id), 32'(lv));

        // wfull held for five cycles after beat 2 of requester 2
        async_reset();
        flush();
        p_new = 0; full_override = 0; wfull = 1'b0;
        repeat (4) pend[2].push_back(DW'($urandom));
        apply_inputs();
        repeat (3) step();
        full_override = 1; wfull = 1'b1;
        repeat (5) step();
        check_val("stall_hold_beats", 32'(wlog.size()), 32'd2);
        full_override = 0; wfull = 1'b0;
        repeat (4) step();
        check_val("stall_beats", 32'(wlog.size()), 32'd4);
        check_val("stall_grants", 32'(glog.size()), 32'd1);
        check_val("stall_gnt", 32'(glog_at(0)), 32'd2);

        // Requester 3 releases after one beat; rotation wraps to 0
        async_reset();
        flush();
        p_new = 0; full_override = 0; wfull = 1'b0;
        pend[3].push_back(8'hA5);
        apply_inputs();
        step();
        repeat (3) pend[0].push_back(DW'($urandom));
        repeat (3) pend[1].push_back(DW'($urandom));
        apply_inputs();
        repeat (3) step();
        check_val("wrap_gid", 32'(grant_id), 32'd0);

        // Random traffic with random wfull, one reset midway
        p_new = 35; len_max = 6; p_full = 25; full_override = -1;
        repeat (700) step();
        async_reset();
        repeat (800) step();
        p_new = 0; full_override = 0; wfull = 1'b0;
        repeat (60) step();
        total = 0;
        for (int i = 0; i < NR; i++) total += pend[i].size();
        check_val("drain", 32'(total), 32'd0);

`ifdef AFIFO_WR_ARB_STATS_EN
        // Long wfull stall saturates the statistics counter
        async_reset();
        flush();
        p_new = 100; len_max = 4; full_override = 1; wfull = 1'b1;
        refill();
        apply_inputs();
        repeat (65600) step();
        check_val("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Shares the async FIFO write port (wclk domain) among NUM_REQ requesters using round-robin arbitration with bounded bursts.
- Each requester presents valid/data and sees a ready; the arbiter drives winc/wdata into the FIFO and never writes while wfull is high.
- Sits between the traffic sources and the FIFO write interface, which the write-side monitor observes.

Parameters:
- DATA_WIDTH, 8, FIFO write data width.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive beats per grant (1..16).

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept.
- wfull  in  1  FIFO full flag (wclk domain).
- winc  out  1  FIFO write enable.
- wdata  out  DATA_WIDTH  FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  currently/last granted requester.
- busy  out  1  high in GRANT state.

Behaviour:
- Clock and reset: one clock, wclk; reset wrst_n is asynchronous, active-low. Reset values: state=IDLE, grant_id=0, last_gnt=NUM_REQ-1 (so requester 0 has first priority), beat_cnt=0, busy=0. Outputs req_ready=0 and winc=0 follow from IDLE.
- FSM IDLE:
  - If any req_valid is high, select the first set bit scanning last_gnt+1, last_gnt+2, ... with modulo NUM_REQ wrap.
  - Register the winner in grant_id, clear beat_cnt, go to GRANT.
  - No transfer in IDLE, giving a 1-cycle arbitration latency.
- FSM GRANT (g = grant_id):
  - req_ready[g] = !wfull; all other ready bits are 0.
  - Transfer when req_valid[g] & req_ready[g].
  - winc = transfer and wdata = req_data slice g, both combinational from registered grant_id; wdata = 0 when no transfer.
  - On transfer: beat_cnt += 1. If beat_cnt reaches MAX_BURST, or req_valid[g] is low in the cycle after a transfer, set last_gnt=g and go to IDLE.
  - If req_valid[g] is low in GRANT with no transfer pending, set last_gnt=g and go to IDLE.
- Handshake rule: once req_valid is asserted, the requester holds it and its data stable until accepted. The arbiter may assume this and need not check it.
- wfull stall: ready=0, winc=0, beat_cnt holds, grant is retained. A stall never counts as a beat and never releases the grant.
- Simultaneous events:
  - wfull rising in the same cycle as a would-be transfer blocks that transfer; winc is never high while wfull is high.
  - A release and a new request in the same cycle pass through IDLE for one cycle.
- Reset mid-burst: immediate return to IDLE; any beat not yet accepted is dropped from the arbiter's view and the requester must re-present it.
- Fairness: each requester waits at most (NUM_REQ-1)*(MAX_BURST+1)+1 cycles for a grant, excluding wfull stalls.

Optional Feature:
- Macro AFIFO_WR_ARB_STATS_EN.
- Defined: adds output stall_cnt [15:0], a saturating count (holds at 16'hFFFF) of cycles in GRANT with req_valid[grant_id]=1 and wfull=1. Cleared by reset only.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Single requester: req_valid[1]=1 with data 0x11,0x22,0x33 in back-to-back beats, wfull=0 → one IDLE cycle, then winc high for 3 consecutive cycles with wdata 0x11,0x22,0x33, grant_id=1.
- All four requesters valid continuously, MAX_BURST=4 → grant order 0,1,2,3,0; each grant gives exactly 4 beats, with a 1-cycle IDLE gap between grants.
- wfull asserted for 5 cycles mid-burst of requester 2 after beat 2 → winc=0 and req_ready[2]=0 for those 5 cycles; beats 3-4 complete afterwards; no re-arbitration during the stall.
- Requester 3 drops valid after 1 beat while requesters 0 and 1 are valid → grant returns to IDLE, then goes to requester 0 (wrap from last_gnt=3).
- wrst_n pulsed low mid-burst → busy=0, winc=0 and req_ready=0 immediately (asynchronously); the first grant after reset goes to the lowest-indexed valid requester.
- With AFIFO_WR_ARB_STATS_EN: hold wfull=1 for 70000 granted-valid cycles → stall_cnt saturates at 16'hFFFF.
